// File: rtl/seg7_bin_display.sv
// ----------------------------------------------------------------------------
// seg7_bin_display
//
// Multi-digit seven-segment driver. The driver accepts an unsigned binary value
// over a valid/ready handshake. A sequential shift-add-3 (double-dabble) engine
// converts the value to BCD, one bit per cycle. The driver then registers
// DIGITS active-low segment patterns for the board HEX displays.
//
// Before the first result is loaded, the top digit shows a pending pattern and
// all other digits are blank. Values >= 10**DIGITS raise overflow and show
// dashes on every digit.
//
// Optional feature (compile-time macro SEG7_LZ_BLANK_EN):
//   When defined, leading zeros are blanked at LOAD. Digit 0 is always shown,
//   and bcd_out is unaffected.
//
// Parameters:
//   WIDTH       binary input width (1..27)
//   DIGITS      displayed decimal digits (1..8)
//   PENDING_PAT pattern on the top digit while no result is loaded
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset      in   asynchronous active-high reset
//   clear      in   synchronous abort; returns the display to pending
//   in_valid   in   in_value is valid
//   in_ready   out  high only in IDLE
//   in_value   in   unsigned binary value [WIDTH-1:0]
//   busy       out  conversion in progress (SHIFT)
//   out_valid  out  display holds a converted result
//   overflow   out  last result >= 10**DIGITS
//   bcd_out    out  registered BCD digits, digit 0 in [3:0]
//   seg_out    out  registered segments, digit i in [7i+6:7i], bit0=a..bit6=g, 0=lit
// ----------------------------------------------------------------------------
module seg7_bin_display #(
    parameter int           WIDTH       = 14,
    parameter int           DIGITS      = 4,
    parameter logic [6:0]   PENDING_PAT = 7'b1010101
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_value,
    output logic                  busy,
    output logic                  out_valid,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out
);

    localparam int         CNT_W     = 5;  // enough for WIDTH up to 27
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    function automatic logic [7*DIGITS-1:0] pending_seg();
        logic [7*DIGITS-1:0] p;
        p = '1;
        p[7*DIGITS-1 -: 7] = PENDING_PAT;
        return p;
    endfunction

    localparam logic [7*DIGITS-1:0] SEG_PENDING = pending_seg();

    function automatic logic [6:0] seg7_of(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1011000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    state_t                state_q;
    logic [WIDTH-1:0]      bin_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  ovf_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  out_valid_q;
    logic                  overflow_q;
    logic [4*DIGITS-1:0]   bcd_out_q;
    logic [7*DIGITS-1:0]   seg_out_q;

    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_d;
    logic                  carry_d;
    logic [7*DIGITS-1:0]   seg_d;

    // One double-dabble step: add 3 to each nibble >= 5, then shift
    // {carry, bcd, bin} left by one. The bit leaving the top nibble is the
    // overflow carry.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d   = {bcd_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
        carry_d = bcd_adj[4*DIGITS-1];
    end

    // Segment pattern loaded at LOAD, decoded from the finished BCD value.
`ifdef SEG7_LZ_BLANK_EN
    logic seen_nz;
    always_comb begin
        seg_d   = '1;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0)
                seen_nz = 1'b1;
            if (ovf_q)
                seg_d[7*i +: 7] = SEG_DASH;
            else if (!seen_nz && i != 0)
                seg_d[7*i +: 7] = SEG_BLANK;  // leading zero
            else
                seg_d[7*i +: 7] = seg7_of(bcd_q[4*i +: 4]);
        end
    end
`else
    always_comb begin
        seg_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            seg_d[7*i +: 7] = ovf_q ? SEG_DASH : seg7_of(bcd_q[4*i +: 4]);
        end
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            // NOTE: sequential state uses non-blocking (<=) so all registers update together.
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            bcd_out_q   <= '0;
            seg_out_q   <= SEG_PENDING;
        end else if (clear) begin
            // Clear wins over a same-cycle handshake and discards any conversion.
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            bcd_out_q   <= '0;
            seg_out_q   <= SEG_PENDING;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bin_q   <= in_value;
                        bcd_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_q << 1;
                    bcd_q <= bcd_d;
                    ovf_q <= ovf_q | carry_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT)
                        state_q <= LOAD;
                end
                LOAD: begin
                    bcd_out_q   <= bcd_q;
                    seg_out_q   <= seg_d;
                    overflow_q  <= ovf_q;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign bcd_out   = bcd_out_q;
    assign seg_out   = seg_out_q;

endmodule

// File: tb/tb_seg7_bin_display.sv
module tb_seg7_bin_display;

    logic        Clk;
    logic        Reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_value;
    logic        busy;
    logic        out_valid;
    logic        overflow;
    logic [15:0] bcd_out;
    logic [27:0] seg_out;

    seg7_bin_display dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .busy      (busy),
        .out_valid (out_valid),
        .overflow  (overflow),
        .bcd_out   (bcd_out),
        .seg_out   (seg_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1011000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;
    localparam logic [27:0] SEG_PEND = {7'b1010101, SB, SB, SB};

    typedef struct {
        logic [13:0] value;
        logic [15:0] bcd;
        logic [27:0] seg;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Handshake one value, measure busy length, check LOAD timing, end in IDLE
    // with the new result on the outputs.
    task automatic convert(input logic [13:0] v, input string name);
        int n;
        @(negedge Clk);
        in_valid = 1'b1;
        in_value = v;
        @(negedge Clk);  // handshake happened on the posedge just passed
        in_valid = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge Clk);
        end
        check({name, " busy_cycles"}, n, 14);
        check({name, " in_ready_in_load"}, in_ready, 0);
        @(negedge Clk);
        check({name, " in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        int n;
        vecs[0] = '{14'd1234,  16'h1234, {S1, S2, S3, S4}, 1'b0};
`ifdef SEG7_LZ_BLANK_EN
        vecs[1] = '{14'd0,     16'h0000, {SB, SB, SB, S0}, 1'b0};
        vecs[4] = '{14'd42,    16'h0042, {SB, SB, S4, S2}, 1'b0};
        vecs[6] = '{14'd7,     16'h0007, {SB, SB, SB, S7}, 1'b0};
`else
        vecs[1] = '{14'd0,     16'h0000, {S0, S0, S0, S0}, 1'b0};
        vecs[4] = '{14'd42,    16'h0042, {S0, S0, S4, S2}, 1'b0};
        vecs[6] = '{14'd7,     16'h0007, {S0, S0, S0, S7}, 1'b0};
`endif
        vecs[2] = '{14'd10000, 16'h0000, {SD, SD, SD, SD}, 1'b1};
        vecs[3] = '{14'd9999,  16'h9999, {S9, S9, S9, S9}, 1'b0};
        vecs[5] = '{14'd16383, 16'h6383, {SD, SD, SD, SD}, 1'b1};
        vecs[7] = '{14'd1005,  16'h1005, {S1, S0, S0, S5}, 1'b0};
        vecs[8] = '{14'd5678,  16'h5678, {S5, S6, S7, S8}, 1'b0};

        Reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_value = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("reset seg", seg_out, SEG_PEND);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset bcd", bcd_out, 0);
        check("reset overflow", overflow, 0);

        for (int i = 0; i < 9; i++) begin
            string nm;
            nm = $sformatf("vec%0d(%0d)", i, vecs[i].value);
            convert(vecs[i].value, nm);
            check({nm, " bcd"}, bcd_out, vecs[i].bcd);
            check({nm, " seg"}, seg_out, vecs[i].seg);
            check({nm, " ovf"}, overflow, vecs[i].ovf);
            check({nm, " out_valid"}, out_valid, 1);
        end

        // in_valid held high: 42 captured, 7 ignored during SHIFT, accepted next IDLE.
        @(negedge Clk);
        in_valid = 1'b1;
        in_value = 14'd42;
        @(negedge Clk);
        in_value = 14'd7;
        check("hold busy", busy, 1);
        check("hold in_ready", in_ready, 0);
        check("hold prev bcd", bcd_out, 16'h5678);
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge Clk);
        end
        check("hold first bcd", bcd_out, 16'h0042);
        @(negedge Clk);
        check("hold second accepted", busy, 1);
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge Clk);
        end
        check("hold second bcd", bcd_out, 16'h0007);

        // clear sampled at T+5 of a conversion.
        @(negedge Clk);
        in_valid = 1'b1;
        in_value = 14'd1234;
        @(posedge Clk);
        repeat (5) @(negedge Clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        check("clear seg", seg_out, SEG_PEND);
        check("clear busy", busy, 0);
        check("clear in_ready", in_ready, 1);
        check("clear out_valid", out_valid, 0);
        check("clear bcd", bcd_out, 0);
        repeat (20) @(negedge Clk);
        check("clear no load", out_valid, 0);
        check("clear seg held", seg_out, SEG_PEND);

        // Reset mid-SHIFT after a completed conversion.
        convert(14'd9999, "pre-reset");
        check("pre-reset out_valid", out_valid, 1);
        @(negedge Clk);
        in_valid = 1'b1;
        in_value = 14'd10000;
        @(posedge Clk);
        repeat (5) @(negedge Clk);
        in_valid = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst seg", seg_out, SEG_PEND);
        check("rst busy", busy, 0);
        check("rst out_valid", out_valid, 0);
        check("rst overflow", overflow, 0);
        repeat (20) @(negedge Clk);
        check("rst no load", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
